operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/operand_entry.sv
// Calculator keypad front end: collects two signed decimal operands and an
// operation from a key strobe stream, presenting them once equals is pressed.
module operand_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       sinal_a,
  output logic       sinal_b,
  output logic [2:0] sel,
  output logic       result_valid,
  output logic       err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_SIGN  = 4'd13;
  localparam logic [3:0] KEY_EQ    = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    SHOW,
    ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    sel_q, sel_d;
  logic          rv_q, rv_d, err_q, err_d;

  logic          is_digit, is_op;
  logic [7:0]    acc;
  logic [CW-1:0] acc_cnt;
  logic [11:0]   prod;
  logic          fits;
  logic [2:0]    op_onehot;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_MUL);

  always_comb begin
    unique case (key_code)
      4'd10:   op_onehot = 3'b100;
      4'd11:   op_onehot = 3'b010;
      4'd12:   op_onehot = 3'b001;
      default: op_onehot = 3'b000;
    endcase
  end

  // Both operand paths share one multiply-accumulate; the state picks the source.
  assign acc     = (state_q == ENTER_B) ? b_q : a_q;
  assign acc_cnt = (state_q == ENTER_B) ? cnt_b_q : cnt_a_q;
  assign prod    = {4'b0, acc} * 12'd10 + {8'b0, key_code};
  assign fits    = (acc_cnt < MAX_CNT) && (prod <= 12'd255);

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    sel_d   = sel_q;
    rv_d    = rv_q;
    err_d   = err_q;

    if (key_valid) begin
      if (key_code == KEY_CLEAR) begin
        state_d = ENTER_A;
        a_d     = '0;
        b_d     = '0;
        sa_d    = 1'b0;
        sb_d    = 1'b0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        op_d    = '0;
        sel_d   = '0;
        rv_d    = 1'b0;
        err_d   = 1'b0;
      end else begin
        unique case (state_q)
          ENTER_A, ENTER_B: begin
            if (is_digit) begin
              if (!fits) begin
                state_d = ERROR;
                a_d     = '0;
                b_d     = '0;
                sa_d    = 1'b0;
                sb_d    = 1'b0;
                cnt_a_d = '0;
                cnt_b_d = '0;
                op_d    = '0;
                err_d   = 1'b1;
              end else if (state_q == ENTER_A) begin
                a_d     = prod[7:0];
                cnt_a_d = cnt_a_q + 1'b1;
              end else begin
                b_d     = prod[7:0];
                cnt_b_d = cnt_b_q + 1'b1;
              end
            end else if (key_code == KEY_SIGN) begin
              if (state_q == ENTER_A) sa_d = ~sa_q;
              else                    sb_d = ~sb_q;
            end else if (is_op) begin
              // Once B has a digit the operation is locked in.
              if (state_q == ENTER_A) begin
                op_d    = op_onehot;
                state_d = ENTER_B;
              end else if (cnt_b_q == '0) begin
                op_d = op_onehot;
              end
            end else if (key_code == KEY_EQ && state_q == ENTER_B) begin
              sel_d   = op_q;
              rv_d    = 1'b1;
              state_d = SHOW;
            end
          end
          SHOW: begin
            if (is_digit) begin
              state_d = ENTER_A;
              a_d     = {4'b0, key_code};
              cnt_a_d = CW'(1);
              b_d     = '0;
              sa_d    = 1'b0;
              sb_d    = 1'b0;
              cnt_b_d = '0;
              op_d    = '0;
              sel_d   = '0;
              rv_d    = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset
  // branch is synchronous and overrides any key sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign sinal_a      = sa_q;
  assign sinal_b      = sb_q;
  assign sel          = sel_q;
  assign result_valid = rv_q;
  assign err          = err_q;

endmodule
